// File: rtl/e1000_pkg.sv
// Shared definitions for the e1000 interrupt block: cause bit positions,
// FSM state encoding and the default throttle prescale.
package e1000_pkg;

  localparam int CAUSE_W = 31;

  localparam int TXDW   = 0;
  localparam int TXQE   = 1;
  localparam int LSC    = 2;
  localparam int RXSEQ  = 3;
  localparam int RXDMT0 = 4;
  localparam int RXO    = 6;
  localparam int RXT0   = 7;
  localparam int MDAC   = 9;

  localparam int INT_ASSERTED = 31;

  localparam int ITR_TICK_CYCLES_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ASSERT = 2'd2
  } intr_state_e;

endpackage

// File: rtl/e1000_itr_timer.sv
// Interrupt throttle timer: a free-running prescaler generates ITR ticks and a
// down-counter holds off the next assertion until it reaches zero.
module e1000_itr_timer
  import e1000_pkg::*;
#(
  parameter int ITR_TICK_CYCLES = ITR_TICK_CYCLES_DEF,
  parameter int TICK_W          = 6
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [15:0] i_itr,
  input  logic        i_load,
  input  logic        i_zero,
  output logic        o_thr_zero
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(ITR_TICK_CYCLES - 1);

  logic [TICK_W-1:0] r_presc;
  logic [15:0]       r_thr_cnt;
  logic              w_tick;

  assign w_tick     = (r_presc == TICK_LAST);
  assign o_thr_zero = (r_thr_cnt == 16'd0);

  // The prescaler never re-phases, so the first interval may be up to one tick short.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)    r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  // A zero ITR write overrides a simultaneous load so throttling stops at once.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                       r_thr_cnt <= 16'd0;
    else if (i_zero)                    r_thr_cnt <= 16'd0;
    else if (i_load)                    r_thr_cnt <= i_itr;
    else if (w_tick && !o_thr_zero)     r_thr_cnt <= r_thr_cnt - 16'd1;
  end

endmodule

// File: rtl/e1000_intr_ctrl.sv
// Interrupt cause/mask/throttle engine: latches hardware and software causes,
// applies the mask and drives a throttled level interrupt.
module e1000_intr_ctrl
  import e1000_pkg::*;
#(
  parameter int ITR_TICK_CYCLES = ITR_TICK_CYCLES_DEF,
  parameter int TICK_W          = 6
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] ICR,
  input  logic        ICR_set,
  input  logic        ICR_get,
  output logic [31:0] ICR_fb,
  input  logic [31:0] ICS,
  input  logic        ICS_set,
  input  logic [31:0] IMS,
  input  logic        IMS_set,
  input  logic [31:0] IMC,
  input  logic        IMC_set,
  input  logic [31:0] ITR,
  input  logic        ITR_set,
  output logic [31:0] IMS_fb,
  input  logic [30:0] evt_i,
  output logic        intr_o
);

  logic [CAUSE_W-1:0] r_cause;
  logic [CAUSE_W-1:0] r_mask;
  logic [15:0]        r_itr;
  intr_state_e        r_state;
  intr_state_e        w_state_nxt;

  logic [CAUSE_W-1:0] w_set;
  logic [CAUSE_W-1:0] w_clr;
  logic [CAUSE_W-1:0] w_mset;
  logic [CAUSE_W-1:0] w_mclr;
  logic               w_pending;
  logic               w_thr_zero;
  logic               w_load;
  logic               w_itr_zero_wr;
  logic               w_unused;

  assign w_set  = evt_i | (ICS_set ? ICS[CAUSE_W-1:0] : '0);
  assign w_clr  = (ICR_set ? ICR[CAUSE_W-1:0] : '0) | {CAUSE_W{ICR_get}};
  assign w_mset = IMS_set ? IMS[CAUSE_W-1:0] : '0;
  assign w_mclr = IMC_set ? IMC[CAUSE_W-1:0] : '0;

  assign w_pending     = |(r_cause & r_mask);
  assign w_itr_zero_wr = ITR_set && (ITR[15:0] == 16'd0);
  assign w_unused      = ^{ITR[31:16], ICR[31], ICS[31], IMS[31], IMC[31]};

  // Set is ORed in after the clear so a coincident event is never lost.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cause <= '0;
      r_mask  <= '0;
      r_itr   <= 16'd0;
    end else begin
      r_cause <= (r_cause & ~w_clr) | w_set;
      r_mask  <= (r_mask | w_mset) & ~w_mclr;
      if (ITR_set) r_itr <= ITR[15:0];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pending) w_state_nxt = w_thr_zero ? ST_ASSERT : ST_WAIT;
      end
      ST_WAIT: begin
        if (!w_pending)      w_state_nxt = ST_IDLE;
        else if (w_thr_zero) w_state_nxt = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (!w_pending) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_load = (r_state != ST_ASSERT) && (w_state_nxt == ST_ASSERT);

  e1000_itr_timer #(
    .ITR_TICK_CYCLES (ITR_TICK_CYCLES),
    .TICK_W          (TICK_W)
  ) u_itr_timer (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .i_itr      (r_itr),
    .i_load     (w_load),
    .i_zero     (w_itr_zero_wr),
    .o_thr_zero (w_thr_zero)
  );

  assign intr_o = (r_state == ST_ASSERT);

  always_comb begin
    ICR_fb               = {1'b0, r_cause};
    ICR_fb[INT_ASSERTED] = intr_o;
  end

  assign IMS_fb = {1'b0, r_mask};

endmodule

// File: doc/e1000_intr_ctrl.md
Name: e1000_intr_ctrl

Overview:
Interrupt cause/mask/throttle engine directly downstream of e1000_regs. It consumes the ICR/ICS/IMS/IMC/ITR write strobes and data from e1000_regs, plus hardware event pulses from the TX/RX/MDIC engines. It returns the ICR and IMS readback values and drives a level interrupt toward the PCI INTx/MSI logic.

Parameters:
ITR_TICK_CYCLES, 32, aclk cycles per ITR unit (256 ns at 125 MHz)
TICK_W, 6, prescaler width; must satisfy 2^TICK_W >= ITR_TICK_CYCLES

Ports:
aclk  in  1  clock
aresetn  in  1  reset, active-low
ICR  in  32  ICR write data (write-1-to-clear)
ICR_set  in  1  ICR write strobe, 1-cycle
ICR_get  in  1  ICR read strobe, 1-cycle (read-to-clear)
ICR_fb  out  32  ICR readback: {intr_o, cause[30:0]}
ICS  in  32  cause-set data
ICS_set  in  1  ICS write strobe
IMS  in  32  mask-set data
IMS_set  in  1  IMS write strobe
IMC  in  32  mask-clear data
IMC_set  in  1  IMC write strobe
ITR  in  32  throttle interval; [15:0] used, [31:16] ignored
ITR_set  in  1  ITR write strobe
IMS_fb  out  32  mask readback: {1'b0, mask[30:0]}
evt_i  in  31  hardware cause pulses, 1 cycle each, bit positions per package
intr_o  out  1  interrupt request, level, registered

Behaviour:
- Clock and reset: one clock, aclk. Reset aresetn is asynchronous and active-low. While reset is asserted, the following are all 0: cause, mask, itr, prescaler, thr_cnt, intr_o. State is IDLE. ICR_fb=0 and IMS_fb=0.
- Cause register: set = evt_i | (ICS_set ? ICS[30:0] : 0).
  - clr = (ICR_set ? ICR[30:0] : 0) | (ICR_get ? all-ones : 0).
  - cause <= (cause & ~clr) | set.
  - Set wins over clear in the same cycle, so no event is lost.
- Mask register: mask <= (mask | (IMS_set ? IMS[30:0] : 0)) & ~(IMC_set ? IMC[30:0] : 0). Clear wins.
- pending = |(cause & mask), combinational from registered values.
- ITR register: itr <= ITR[15:0] on ITR_set.
- Throttle timer:
  - Free-running prescaler emits tick every ITR_TICK_CYCLES cycles.
  - thr_cnt decrements by 1 on tick while nonzero and never wraps below 0.
  - thr_cnt is loaded with itr on the IDLE/WAIT->ASSERT transition.
  - ITR_set with ITR[15:0]==0 forces thr_cnt to 0 in the next cycle. Other ITR writes do not disturb a running count.
  - First-interval resolution is -1 tick (prescaler is not re-phased).
- FSM (intr_o = state==ASSERT):
  - IDLE: pending && thr_cnt==0 -> ASSERT; pending && thr_cnt!=0 -> WAIT.
  - WAIT: !pending -> IDLE; thr_cnt==0 -> ASSERT.
  - ASSERT: !pending -> IDLE. Pending drops via ICR read/clear or an IMC write.
  - ITR==0 disables throttling.
- Latency:
  - evt_i/ICS at edge N -> ICR_fb bit at N+1 -> intr_o at N+2 (unthrottled, unmasked).
  - ICR_get at edge N -> cause=0 at N+1 -> intr_o=0 at N+2.
- ICR_fb[31] reflects intr_o. Bits returned on an ICR read are the values before the clear.
- Reset mid-ASSERT or mid-WAIT drops intr_o immediately and discards the throttle count.

Decomposition:
- Shared package e1000_pkg holds:
  - cause bit indices: TXDW=0, TXQE=1, LSC=2, RXSEQ=3, RXDMT0=4, RXO=6, RXT0=7, MDAC=9.
  - INT_ASSERTED=31.
  - FSM state encoding: IDLE/WAIT/ASSERT.
  - default ITR_TICK_CYCLES.
- One sub-module: e1000_itr_timer (prescaler, thr_cnt, load/zero/tick logic; outputs thr_zero).

Test Plan:
- Basic assert/clear:
  - Stimulus: reset; IMS_set 0x0000_0080; evt_i[7] pulse at edge N.
  - Required: ICR_fb=0x0000_0080 at N+1; intr_o=1 and ICR_fb=0x8000_0080 at N+2.
  - Then ICR_get -> ICR_fb=0 and intr_o=0 within 2 cycles.
- Masked cause:
  - Stimulus: mask 0; ICS_set 0x0000_0004.
  - Required: ICR_fb=0x0000_0004 with intr_o=0 for 100 cycles; IMS_set 0x4 -> intr_o=1 two cycles later.
- Throttle:
  - Stimulus: ITR_set 4; event -> assert at cycle A; ICR_get; new event immediately.
  - Required: intr_o reasserts no earlier than A+96 and no later than A+130.
  - Then ITR_set 0 during WAIT -> intr_o within 3 cycles.
- Simultaneous set and clear:
  - ICR_get coincident with evt_i[0] -> cause=0x1 afterward.
  - Cause 0x81, ICR_set 0x01 -> ICR_fb=0x80.
  - IMS_set and IMC_set both 0x4 in the same cycle -> IMS_fb=0.
- Mask removal: intr_o=1; IMC_set of the pending bit -> intr_o=0 at +2; cause retained in ICR_fb.
- Reset mid-operation: assert aresetn=0 asynchronously during ASSERT -> intr_o=0 before the next aclk edge. ICR_fb=0 and IMS_fb=0 after release.
